// File: rtl/main_memory_ctrl_pkg.sv
// rtl/main_memory_ctrl_pkg.sv - shared types, defaults and helpers for the main memory controller
package mem_pkg;

  localparam int MEM_AW  = 8;
  localparam int MEM_DW  = 8;
  localparam int MEM_M   = 32;
  localparam int MEM_LAT = 3;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Statistics counters stick at CNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 8'd1;
  endfunction

endpackage

// File: rtl/main_memory_ctrl_if.sv
// rtl/main_memory_ctrl_if.sv - request/response channel and statistics bundle
interface main_memory_ctrl_if
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [7:0]    rd_count;
  logic [7:0]    wr_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, rd_count, wr_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, rd_count, wr_count
  );

endinterface

// File: rtl/main_memory_ctrl_array.sv
// rtl/main_memory_ctrl_array.sv - M x DW backing store, synchronous write, combinational read
module main_mem_array
  import mem_pkg::*;
#(
  parameter int M  = MEM_M,
  parameter int DW = MEM_DW,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Contents survive reset on purpose: only the controller state is cleared.
  logic [DW-1:0] mem_q [M];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/main_memory_ctrl.sv
// rtl/main_memory_ctrl.sv - single-outstanding backing store with fixed access latency and saturating stats
module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int M   = MEM_M,
  parameter int AW  = MEM_AW,
  parameter int DW  = MEM_DW,
  parameter int LAT = MEM_LAT
) (
  input  logic               clk,
  input  logic               rst,
  main_memory_ctrl_if.slave  bus
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0]    IDLE     = ST_IDLE;
  localparam logic [1:0]    WAIT     = ST_WAIT;
  localparam logic [1:0]    RESP     = ST_RESP;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  generate
    if (LAT < 1) begin : g_bad_lat
      $error("main_memory_ctrl: LAT must be >= 1");
    end
    if (IW > AW) begin : g_bad_depth
      $error("main_memory_ctrl: M does not fit in AW address bits");
    end
  endgenerate

  logic [1:0]    state_q,      state_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic          we_q,         we_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic [DW-1:0] wdata_q,      wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q,   resp_err_d;
  logic [7:0]    rd_count_q,   rd_count_d;
  logic [7:0]    wr_count_q,   wr_count_d;

  logic          in_range;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  // Full-width compare: out-of-range addresses are errors, never aliased.
  assign in_range = (32'(addr_q) < 32'(M));

  main_mem_array #(
    .M  (M),
    .DW (DW),
    .IW (IW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[IW-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Completion edge: the array write lands together with the response.
          resp_valid_d = 1'b1;
          state_d      = RESP;
          if (!in_range) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (we_q) begin
            mem_we       = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            wr_count_d   = sat_inc(wr_count_q);
          end else begin
            resp_rdata_d = mem_rdata;
            resp_err_d   = 1'b0;
            rd_count_d   = sat_inc(rd_count_q);
          end
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.rd_count   = rd_count_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb/tb_main_memory_ctrl.sv - self-checking bench for main_memory_ctrl
module tb_main_memory_ctrl;

  localparam int M   = 32;
  localparam int LAT = 3;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic   clk;
  logic   rst;
  int     checks;
  int     errors;
  longint cyc;
  longint prev_acc;
  bit     have_prev;
  int     rd_model;
  int     wr_model;
  exp_t   sb_q[$];
  vec_t   vecs[14];

  main_memory_ctrl_if #(.AW(8), .DW(8)) bus ();

  main_memory_ctrl #(
    .M   (M),
    .AW  (8),
    .DW  (8),
    .LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sampled 1 time unit after the falling edge: sees what the next rising edge will see.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", bus.resp_err, e.err);
      end
    end
  end

  task automatic xact(input vec_t v);
    int     n;
    longint acc;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", bus.req_ready, 1);
    acc = cyc + 1;
    if (have_prev) chk("accept_spacing_ok", (acc - prev_acc) >= (LAT + 2), 1);
    prev_acc  = acc;
    have_prev = 1'b1;
    sb_q.push_back('{v.exp_rdata, v.exp_err});
    if (v.addr < M) begin
      if (v.we) wr_model = (wr_model == 255) ? 255 : wr_model + 1;
      else      rd_model = (rd_model == 255) ? 255 : rd_model + 1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    chk("req_ready_busy", bus.req_ready, 0);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid_seen", bus.resp_valid, 1);
    chk("latency", cyc - acc, LAT);
    chk("rd_count", bus.rd_count, rd_model);
    chk("wr_count", bus.wr_count, wr_model);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    have_prev = 1'b0;
    rd_model  = 0;
    wr_model  = 0;

    vecs[0]  = '{1'b1, 8'd5,   8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'd5,   8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'd40,  8'h00, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'd5,   8'h00, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 8'd7,   8'h11, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'd7,   8'h00, 8'h11, 1'b0};
    vecs[6]  = '{1'b1, 8'd31,  8'h5A, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'd31,  8'h00, 8'h5A, 1'b0};
    vecs[8]  = '{1'b1, 8'd0,   8'h77, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 8'd32,  8'hFF, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 8'd0,   8'h00, 8'h77, 1'b0};
    vecs[11] = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 8'd5,   8'hC3, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 8'd5,   8'hA5, 8'h00, 1'b0};

    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_rd_count", bus.rd_count, 0);
    chk("rst_wr_count", bus.wr_count, 0);

    for (int i = 0; i < 14; i++) xact(vecs[i]);

    // Backpressure: response must hold while resp_ready is low.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    xact('{1'b0, 8'd5, 8'h00, 8'hA5, 1'b0});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_resp_rdata", bus.resp_rdata, 8'hA5);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_req_ready", bus.req_ready, 1);
    chk("bp_done_resp_valid", bus.resp_valid, 0);
    chk("bp_hold_rdata", bus.resp_rdata, 8'hA5);

    // Reset while a write to addr 7 sits in WAIT with cnt==1.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'd7;
    bus.req_wdata = 8'h3C;
    chk("abort_accept_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_resp_rdata", bus.resp_rdata, 0);
    chk("abort_resp_err", bus.resp_err, 0);
    chk("abort_rd_count", bus.rd_count, 0);
    chk("abort_wr_count", bus.wr_count, 0);
    rd_model  = 0;
    wr_model  = 0;
    have_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xact('{1'b0, 8'd7, 8'h00, 8'h11, 1'b0});

    for (int i = 0; i < 260; i++) xact('{1'b0, 8'd5, 8'h00, 8'hA5, 1'b0});
    repeat (2) @(negedge clk);
    chk("rd_count_saturated", bus.rd_count, 255);
    chk("wr_count_after_sat", bus.wr_count, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
